// File: rtl/conv_addr_iter.sv
// Purpose: walks one conv layer (kx, ky, ic, ox, oy, oc; innermost first) and emits data/weight/bias/output addresses per tap.
// Latency: outputs are registered one cycle after the counter state; the first valid tap appears two cycles after go is sampled.
// Backpressure: stall=1 freezes the counters, the FSM exit and every output register; a tap is consumed on valid=1 && stall=0.
module conv_addr_iter #(
    parameter int OUT_CH = 5,
    parameter int IN_CH  = 1,
    parameter int KX     = 5,
    parameter int KY     = 5,
    parameter int STRIDE = 1,
    parameter int PAD    = 0,
    parameter int IN_W   = 28,
    parameter int IN_H   = 28,
    parameter int AW     = 12,
    parameter int WW     = 12,
    parameter int BW     = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          go,
    input  logic          stall,
    output logic          busy,
    output logic          valid,
    output logic          first_data,
    output logic          last_data,
    output logic          pad_zero,
    output logic [AW-1:0] aa_data,
    output logic [WW-1:0] aa_weight,
    output logic [BW-1:0] aa_bias,
    output logic [AW-1:0] aa_out,
    output logic          done
);

    // Output plane geometry.
    localparam int OUT_W = (IN_W + 2 * PAD - KX) / STRIDE + 1;
    localparam int OUT_H = (IN_H + 2 * PAD - KY) / STRIDE + 1;

    // Counter widths; a dimension of size 1 still gets a 1-bit counter.
    localparam int KXW = (KX > 1) ? $clog2(KX) : 1;
    localparam int KYW = (KY > 1) ? $clog2(KY) : 1;
    localparam int ICW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
    localparam int OXW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int OYW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int OCW = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

    localparam logic [KXW-1:0] KX_MAX = KXW'(KX - 1);
    localparam logic [KYW-1:0] KY_MAX = KYW'(KY - 1);
    localparam logic [ICW-1:0] IC_MAX = ICW'(IN_CH - 1);
    localparam logic [OXW-1:0] OX_MAX = OXW'(OUT_W - 1);
    localparam logic [OYW-1:0] OY_MAX = OYW'(OUT_H - 1);
    localparam logic [OCW-1:0] OC_MAX = OCW'(OUT_CH - 1);

    // IDLE: waiting for go. RUN: counters issue one tap per unstalled cycle.
    // DRAIN: the final tap sits in the output registers until it is consumed;
    // this is what lets a stall on the final tap push back busy/done.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]     r_state;
    logic           r_busy;
    logic           r_done;

    logic [KXW-1:0] r_kx;
    logic [KYW-1:0] r_ky;
    logic [ICW-1:0] r_ic;
    logic [OXW-1:0] r_ox;
    logic [OYW-1:0] r_oy;
    logic [OCW-1:0] r_oc;

    logic           r_valid;
    logic           r_first;
    logic           r_last;
    logic           r_pad;
    logic [AW-1:0]  r_aa_data;
    logic [WW-1:0]  r_aa_weight;
    logic [BW-1:0]  r_aa_bias;
    logic [AW-1:0]  r_aa_out;

    logic           w_run;
    logic           w_adv;
    logic           w_kx_max;
    logic           w_ky_max;
    logic           w_ic_max;
    logic           w_ox_max;
    logic           w_oy_max;
    logic           w_oc_max;
    logic           w_c_ky;
    logic           w_c_ic;
    logic           w_c_ox;
    logic           w_c_oy;
    logic           w_c_oc;
    logic           w_final;
    logic           w_first;
    logic           w_pad;
    int             w_ix;
    int             w_iy;
    int             w_data_lin;
    int             w_weight_lin;
    int             w_out_lin;

    assign w_run = (r_state == S_RUN);
    assign w_adv = w_run && !stall;

    // Per-counter wrap flags and the carry chain, innermost (kx) first.
    assign w_kx_max = (r_kx == KX_MAX);
    assign w_ky_max = (r_ky == KY_MAX);
    assign w_ic_max = (r_ic == IC_MAX);
    assign w_ox_max = (r_ox == OX_MAX);
    assign w_oy_max = (r_oy == OY_MAX);
    assign w_oc_max = (r_oc == OC_MAX);

    assign w_c_ky  = w_kx_max;
    assign w_c_ic  = w_c_ky && w_ky_max;
    assign w_c_ox  = w_c_ic && w_ic_max;
    assign w_c_oy  = w_c_ox && w_ox_max;
    assign w_c_oc  = w_c_oy && w_oy_max;
    assign w_final = w_c_oc && w_oc_max;

    assign w_first = (r_kx == '0) && (r_ky == '0) && (r_ic == '0);

    // Address arithmetic in 32-bit signed space so negative (padding) coordinates are visible.
    always_comb begin
        w_iy         = int'(r_oy) * STRIDE + int'(r_ky) - PAD;
        w_ix         = int'(r_ox) * STRIDE + int'(r_kx) - PAD;
        w_pad        = (w_iy < 0) || (w_iy >= IN_H) || (w_ix < 0) || (w_ix >= IN_W);
        w_data_lin   = int'(r_ic) * IN_W * IN_H + w_iy * IN_W + w_ix;
        w_weight_lin = ((int'(r_oc) * IN_CH + int'(r_ic)) * KY + int'(r_ky)) * KX + int'(r_kx);
        w_out_lin    = int'(r_oc) * OUT_W * OUT_H + int'(r_oy) * OUT_W + int'(r_ox);
    end

    // Loop-nest counters: held at zero outside RUN, advance one tap per unstalled RUN cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ic <= '0;
            r_ox <= '0;
            r_oy <= '0;
            r_oc <= '0;
        end else if (r_state == S_IDLE) begin
            r_kx <= '0;
            r_ky <= '0;
            r_ic <= '0;
            r_ox <= '0;
            r_oy <= '0;
            r_oc <= '0;
        end else if (w_adv) begin
            r_kx <= w_kx_max ? '0 : r_kx + KXW'(1);
            if (w_c_ky) r_ky <= w_ky_max ? '0 : r_ky + KYW'(1);
            if (w_c_ic) r_ic <= w_ic_max ? '0 : r_ic + ICW'(1);
            if (w_c_ox) r_ox <= w_ox_max ? '0 : r_ox + OXW'(1);
            if (w_c_oy) r_oy <= w_oy_max ? '0 : r_oy + OYW'(1);
            if (w_c_oc) r_oc <= w_oc_max ? '0 : r_oc + OCW'(1);
        end
    end

    // Control FSM with busy and the one-cycle done pulse; go is only looked at in IDLE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_adv && w_final) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Tap output registers: reload every unstalled cycle, zero whenever the iterator is not running.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid     <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_pad       <= 1'b0;
            r_aa_data   <= '0;
            r_aa_weight <= '0;
            r_aa_bias   <= '0;
            r_aa_out    <= '0;
        end else if (!stall) begin
            r_valid     <= w_run;
            r_first     <= w_run && w_first;
            r_last      <= w_run && w_c_ox;
            r_pad       <= w_run && w_pad;
            r_aa_data   <= (w_run && !w_pad) ? AW'(w_data_lin) : '0;
            r_aa_weight <= w_run ? WW'(w_weight_lin) : '0;
            r_aa_bias   <= w_run ? BW'(int'(r_oc)) : '0;
            r_aa_out    <= w_run ? AW'(w_out_lin) : '0;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign valid      = r_valid;
    assign first_data = r_first;
    assign last_data  = r_last;
    assign pad_zero   = r_pad;
    assign aa_data    = r_aa_data;
    assign aa_weight  = r_aa_weight;
    assign aa_bias    = r_aa_bias;
    assign aa_out     = r_aa_out;

endmodule

// File: tb/tb_conv_addr_iter.sv
// Bench for conv_addr_iter: padded, strided, two-channel layer driven with random stall and stray go pulses.
// Expected taps come from a table built with plain nested loops; handshake timing from a displayed-tap model.
// Covers reset, clean run, final-tap stall, back-to-back go on done, mid-run reset abort and rerun.
module tb_conv_addr_iter;

    localparam int OUT_CH = 2;
    localparam int IN_CH  = 2;
    localparam int KX     = 3;
    localparam int KY     = 3;
    localparam int STRIDE = 2;
    localparam int PAD    = 1;
    localparam int IN_W   = 6;
    localparam int IN_H   = 5;
    localparam int AW     = 12;
    localparam int WW     = 12;
    localparam int BW     = 4;

    localparam int OW = (IN_W + 2 * PAD - KX) / STRIDE + 1;
    localparam int OH = (IN_H + 2 * PAD - KY) / STRIDE + 1;
    localparam int N  = OUT_CH * OH * OW * IN_CH * KY * KX;

    typedef struct {
        int data;
        int weight;
        int bias;
        int outa;
        bit pad;
        bit first;
        bit last;
    } tap_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          go;
    logic          stall;
    logic          busy;
    logic          valid;
    logic          first_data;
    logic          last_data;
    logic          pad_zero;
    logic [AW-1:0] aa_data;
    logic [WW-1:0] aa_weight;
    logic [BW-1:0] aa_bias;
    logic [AW-1:0] aa_out;
    logic          done;

    tap_t tbl[N];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: 0 idle, 1 accepted but no tap shown yet, 2 showing tap m_k.
    int m_ph   = 0;
    int m_k    = 0;
    bit m_done = 1'b0;
    int dut_cons = 0;

    conv_addr_iter #(
        .OUT_CH(OUT_CH), .IN_CH(IN_CH), .KX(KX), .KY(KY), .STRIDE(STRIDE),
        .PAD(PAD), .IN_W(IN_W), .IN_H(IN_H), .AW(AW), .WW(WW), .BW(BW)
    ) dut (
        .clk(clk), .rstn(rstn), .go(go), .stall(stall),
        .busy(busy), .valid(valid), .first_data(first_data), .last_data(last_data),
        .pad_zero(pad_zero), .aa_data(aa_data), .aa_weight(aa_weight),
        .aa_bias(aa_bias), .aa_out(aa_out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic build_tbl();
        int k;
        int iy;
        int ix;
        k = 0;
        for (int oc = 0; oc < OUT_CH; oc++)
            for (int oy = 0; oy < OH; oy++)
                for (int ox = 0; ox < OW; ox++)
                    for (int ic = 0; ic < IN_CH; ic++)
                        for (int ky = 0; ky < KY; ky++)
                            for (int kx = 0; kx < KX; kx++) begin
                                iy = oy * STRIDE + ky - PAD;
                                ix = ox * STRIDE + kx - PAD;
                                tbl[k].pad    = (iy < 0) || (iy >= IN_H) || (ix < 0) || (ix >= IN_W);
                                tbl[k].data   = tbl[k].pad ? 0 : ((ic * IN_W * IN_H + iy * IN_W + ix) & ((1 << AW) - 1));
                                tbl[k].weight = (((oc * IN_CH + ic) * KY + ky) * KX + kx) & ((1 << WW) - 1);
                                tbl[k].bias   = oc & ((1 << BW) - 1);
                                tbl[k].outa   = (oc * OW * OH + oy * OW + ox) & ((1 << AW) - 1);
                                tbl[k].first  = (kx == 0) && (ky == 0) && (ic == 0);
                                tbl[k].last   = (kx == KX - 1) && (ky == KY - 1) && (ic == IN_CH - 1);
                                k++;
                            end
    endtask

    task automatic check_zero();
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_first", first_data, 0);
        chk("rst_last", last_data, 0);
        chk("rst_pad", pad_zero, 0);
        chk("rst_data", aa_data, 0);
        chk("rst_weight", aa_weight, 0);
        chk("rst_bias", aa_bias, 0);
        chk("rst_out", aa_out, 0);
        chk("rst_done", done, 0);
    endtask

    // One clock: drive inputs after the edge, check at the falling edge, then step the model.
    task automatic cyc(input bit g, input bit s);
        @(posedge clk);
        #1;
        go    = g;
        stall = s;
        @(negedge clk);
        chk("busy", busy, (m_ph != 0));
        chk("valid", valid, (m_ph == 2));
        chk("done", done, m_done);
        if (m_ph == 2) begin
            chk("aa_data", aa_data, tbl[m_k].data);
            chk("aa_weight", aa_weight, tbl[m_k].weight);
            chk("aa_bias", aa_bias, tbl[m_k].bias);
            chk("aa_out", aa_out, tbl[m_k].outa);
            chk("pad_zero", pad_zero, tbl[m_k].pad);
            chk("first_data", first_data, tbl[m_k].first);
            chk("last_data", last_data, tbl[m_k].last);
        end else begin
            chk("first_idle", first_data, 0);
            chk("last_idle", last_data, 0);
        end
        if (valid === 1'b1 && !s) dut_cons++;
        m_done = 1'b0;
        case (m_ph)
            0: if (g) m_ph = 1;
            1: if (!s) begin m_ph = 2; m_k = 0; end
            default: if (!s) begin
                if (m_k == N - 1) begin
                    m_ph   = 0;
                    m_done = 1'b1;
                end else begin
                    m_k++;
                end
            end
        endcase
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0);
    endtask

    // Asynchronous abort in the middle of a cycle; outputs must clear before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rstn  = 1'b0;
        go    = 1'b0;
        stall = 1'b0;
        #1;
        check_zero();
        @(negedge clk);
        check_zero();
        @(negedge clk);
        rstn   = 1'b1;
        m_ph   = 0;
        m_k    = 0;
        m_done = 1'b0;
    endtask

    // One layer: go, random stall / stray go while busy, optional 3-cycle stall on the final tap,
    // optional reset abort when tap abort_at is on the outputs.
    task automatic run(input int pct, input bit fstall, input int abort_at);
        int cnt;
        int fs;
        bit s;
        cnt = 0;
        fs  = 0;
        dut_cons = 0;
        cyc(1'b1, 1'b0);
        while (m_ph != 0 && cnt < 4000) begin
            if (abort_at >= 0 && m_ph == 2 && m_k == abort_at) begin
                do_reset();
                return;
            end
            s = ($urandom_range(99) < pct);
            if (fstall && m_ph == 2 && m_k == N - 1 && fs < 3) begin
                s = 1'b1;
                fs++;
            end
            cyc(($urandom_range(5) == 0), s);
            cnt++;
        end
        if (cnt >= 4000) chk("run_timeout_busy", busy, 0);
        chk("taps_consumed", dut_cons, 324);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn  = 1'b0;
        go    = 1'b0;
        stall = 1'b0;
        build_tbl();
        repeat (2) @(negedge clk);
        check_zero();
        rstn = 1'b1;
        idle(2);
        run(0, 1'b0, -1);
        idle(3);
        run(30, 1'b1, -1);
        run(0, 1'b0, -1);
        idle(2);
        run(20, 1'b0, 20);
        idle(2);
        run(25, 1'b1, -1);
        idle(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_addr_iter.md
Name: conv_addr_iter

Overview:
- Next-generation convolution address iterator. Generates data/weight/bias/output SRAM addresses for one full conv layer.
- Adds over the previous iterator:
  - multi-input-channel accumulation
  - configurable stride and zero padding
  - downstream stall
  - output-pixel address
  - explicit busy/done handshake
- Sits between the layer controller (drives go, watches done) and the SRAM read ports / MAC array (consume addresses, valid, first, last, pad_zero).

Parameters:
- OUT_CH, 5, output channels (filters)
- IN_CH, 1, input channels accumulated per output pixel
- KX, 5, kernel width
- KY, 5, kernel height
- STRIDE, 1, stride, both axes (>=1)
- PAD, 0, zero-padding on each border (0..KX-1)
- IN_W, 28, input plane width
- IN_H, 28, input plane height
- AW, 12, width of aa_data and aa_out
- WW, 12, width of aa_weight
- BW, 4, width of aa_bias

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- go  in  1  start pulse; ignored while busy=1
- stall  in  1  downstream backpressure; freezes iterator and outputs
- busy  out  1  high from the cycle after an accepted go until done
- valid  out  1  current aa_* tap is meaningful
- first_data  out  1  first tap of an output pixel (kx=ky=ic=0)
- last_data  out  1  last tap of an output pixel (kx=KX-1, ky=KY-1, ic=IN_CH-1)
- pad_zero  out  1  tap falls in the padding region; MAC must use 0 as data
- aa_data  out  AW  input-feature address
- aa_weight  out  WW  weight address
- aa_bias  out  BW  bias address (= oc)
- aa_out  out  AW  output-feature address of the current pixel
- done  out  1  one-cycle pulse after the final tap is accepted

Behaviour:
- Derived constants:
  - OUT_W = (IN_W + 2*PAD - KX)/STRIDE + 1
  - OUT_H = (IN_H + 2*PAD - KY)/STRIDE + 1
- Loop nest, innermost first: kx, ky, ic, ox, oy, oc. Each counter wraps to 0 at its max and carries to the next.
- Reset: all outputs 0, including first_data and last_data. FSM returns to IDLE; all counters 0.
- FSM states:
  - IDLE: counters held at 0.
  - On go: go to RUN, busy<=1.
  - RUN: counters advance one tap per cycle when stall=0.
  - On the final tap (all counters at max) advancing with stall=0: go to IDLE, counters clear, busy<=0.
- Output timing: all outputs are registered from counter state with 1-cycle latency. The first valid tap appears 2 cycles after go is sampled.
- Outputs computed each unstalled cycle:
  - valid <= (state==RUN)
  - first_data and last_data per the port definitions, qualified by RUN
  - aa_bias <= oc
  - aa_weight <= ((oc*IN_CH + ic)*KY + ky)*KX + kx
  - aa_out <= oc*OUT_W*OUT_H + oy*OUT_W + ox
  - iy = oy*STRIDE + ky - PAD and ix = ox*STRIDE + kx - PAD, computed signed and one bit wider than needed
  - If iy<0, iy>=IN_H, ix<0 or ix>=IN_W: pad_zero<=1 and aa_data<=0.
  - Otherwise: pad_zero<=0 and aa_data <= ic*IN_W*IN_H + iy*IN_W + ix.
  - All address results are truncated to the port width. Sizing the widths is the integrator's duty; no saturation.
- Stall:
  - When stall=1, counters and all output registers hold their values; valid stays as is.
  - A tap counts as consumed only in a cycle with valid=1 and stall=0.
  - A stall arriving in the same cycle as the final tap delays the FSM exit and done.
- done: registered pulse, high for exactly 1 cycle, the cycle after the final tap is consumed (coincident with busy falling). Not raised while stall holds.
- go while busy: ignored. No restart, no queuing.
- go in the same cycle as done: accepted, because the FSM is already in IDLE at that edge. A new run starts back-to-back.
- Reset mid-run: immediate abort. Outputs return to 0; no done is produced.

Test Plan:
- Basic run (IN_W=IN_H=4, KX=KY=3, STRIDE=1, PAD=0, IN_CH=OUT_CH=1), go pulse -> 36 valid cycles. First tap aa_data=0. Tap 9 has aa_data=10, last_data=1. Tap 10 has aa_data=1, first_data=1, aa_out=1. done 1 cycle after tap 36; busy low after.
- Padding (IN_W=IN_H=4, K=3, PAD=1) -> OUT_W=OUT_H=4, 144 taps. Tap 0 (ix=iy=-1) pad_zero=1, aa_data=0. Tap 4 (ky=1, kx=1) pad_zero=0, aa_data=0.
- Stride/channels (IN_W=IN_H=5, K=3, STRIDE=2, IN_CH=2, OUT_CH=2) -> 4 pixels × 18 taps × 2 oc = 144 taps. Pixel 1 first tap aa_data=2. ic=1 taps offset by 25. aa_weight spans 0..35. aa_bias=1 for the second half.
- Stall: assert stall for 3 cycles at tap 5 -> aa_* and valid frozen for 3 cycles; tap 6 follows. Total run length +3. Stall on the final tap delays done by the stall length.
- go pulses during busy -> no effect on counters or tap count. go coincident with done -> second run starts immediately with the same sequence.
- rstn low at tap 20 -> all outputs 0 asynchronously, no done. A subsequent go reproduces the full sequence from tap 0.
